ex_stage_ctrl: RTL and testbench

- ID/EX pipeline register plus architectural status register (N,Z,C,V) and condition-code evaluation for the execute stage.
- Holds the decoded instruction for the ALU and supplies carry-in and operands to it.
- Captures the ALU's 4-bit status {n,z,c,v} back into the status register.
- Annuls writes for instructions whose condition fails, and resolves branches (taken flag and target).

---
 rtl/ex_stage_ctrl_pkg.sv | 23 ++
 rtl/ex_stage_ctrl_if.sv | 56 +++++
 rtl/ex_stage_ctrl_cond_check.sv | 38 +++
 rtl/ex_stage_ctrl.sv | 105 ++++++++++
 tb/tb_ex_stage_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_ctrl_pkg.sv
// Shared definitions for the execute-stage controller: condition codes,
// status flag bit positions and ALU command encodings.
package ex_stage_ctrl_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef enum logic [3:0] {
    EXE_MOV = 4'b0001, EXE_MVN = 4'b1001, EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011, EXE_SUB = 4'b0100, EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110, EXE_ORR = 4'b0111, EXE_EOR = 4'b1000
  } exe_cmd_e;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

endpackage

// File: rtl/ex_stage_ctrl_if.sv
// Bundle between decode, the execute-stage controller and the ALU:
// incoming decoded slot, hazard controls, ALU status and registered EX fields.
interface ex_stage_ctrl_if #(
  parameter int N    = 32,
  parameter int RA_W = 4
);
  logic            freeze;
  logic            flush;
  logic            valid_in;
  logic [3:0]      cond_in;
  logic [3:0]      exe_cmd_in;
  logic            s_in;
  logic            wb_en_in;
  logic            mem_r_in;
  logic            mem_w_in;
  logic            b_in;
  logic [N-1:0]    val_rn_in;
  logic [N-1:0]    val2_in;
  logic [N-1:0]    val_rm_in;
  logic [RA_W-1:0] dest_in;
  logic [N-1:0]    pc_in;
  logic [23:0]     imm24_in;
  logic [3:0]      alu_status;

  logic [3:0]      exe_cmd;
  logic [N-1:0]    val_rn;
  logic [N-1:0]    val2;
  logic [N-1:0]    val_rm;
  logic [RA_W-1:0] dest;
  logic [N-1:0]    pc;
  logic            carry_in;
  logic            wb_en;
  logic            mem_r;
  logic            mem_w;
  logic            cond_pass;
  logic            branch_taken;
  logic [N-1:0]    branch_target;
  logic [3:0]      status_q;

  modport master (
    output freeze, flush, valid_in, cond_in, exe_cmd_in, s_in, wb_en_in,
           mem_r_in, mem_w_in, b_in, val_rn_in, val2_in, val_rm_in, dest_in,
           pc_in, imm24_in, alu_status,
    input  exe_cmd, val_rn, val2, val_rm, dest, pc, carry_in, wb_en, mem_r,
           mem_w, cond_pass, branch_taken, branch_target, status_q
  );

  modport slave (
    input  freeze, flush, valid_in, cond_in, exe_cmd_in, s_in, wb_en_in,
           mem_r_in, mem_w_in, b_in, val_rn_in, val2_in, val_rm_in, dest_in,
           pc_in, imm24_in, alu_status,
    output exe_cmd, val_rn, val2, val_rm, dest, pc, carry_in, wb_en, mem_r,
           mem_w, cond_pass, branch_taken, branch_target, status_q
  );

endinterface

// File: rtl/ex_stage_ctrl_cond_check.sv
// ARM condition-field evaluation against the {N,Z,C,V} flags; purely combinational.
module ex_stage_ctrl_cond_check
  import ex_stage_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       pass
);
  logic n, z, c, v;

  assign n = status[ST_N];
  assign z = status[ST_Z];
  assign c = status[ST_C];
  assign v = status[ST_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_stage_ctrl.sv
// ID/EX pipeline register with the architectural flag register, condition
// gating of side effects and branch resolution for the execute stage.
module ex_stage_ctrl #(
  parameter int N    = 32,
  parameter int RA_W = 4
) (
  input logic           clk,
  input logic           rst,
  ex_stage_ctrl_if.slave bus
);
  import ex_stage_ctrl_pkg::*;

  logic            valid_reg, s_reg, wb_en_reg, mem_r_reg, mem_w_reg, b_reg;
  logic [3:0]      cond_reg, exe_cmd_reg, status_reg;
  logic [N-1:0]    val_rn_reg, val2_reg, val_rm_reg, pc_reg;
  logic [RA_W-1:0] dest_reg;
  logic [23:0]     imm24_reg;
  logic            cond_pass;
  logic            live;
  logic [N-1:0]    imm_sext;

  ex_stage_ctrl_cond_check u_cond_check (
    .cond   (cond_reg),
    .status (status_reg),
    .pass   (cond_pass)
  );

  // Control bits: a flush always wins and inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      s_reg     <= 1'b0;
      wb_en_reg <= 1'b0;
      mem_r_reg <= 1'b0;
      mem_w_reg <= 1'b0;
      b_reg     <= 1'b0;
    end else if (bus.flush) begin
      valid_reg <= 1'b0;
      s_reg     <= 1'b0;
      wb_en_reg <= 1'b0;
      mem_r_reg <= 1'b0;
      mem_w_reg <= 1'b0;
      b_reg     <= 1'b0;
    end else if (!bus.freeze) begin
      valid_reg <= bus.valid_in;
      s_reg     <= bus.s_in;
      wb_en_reg <= bus.wb_en_in;
      mem_r_reg <= bus.mem_r_in;
      mem_w_reg <= bus.mem_w_in;
      b_reg     <= bus.b_in;
    end
  end

  // Data fields are meaningless behind a bubble, so they simply load on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cond_reg    <= '0;
      exe_cmd_reg <= '0;
      val_rn_reg  <= '0;
      val2_reg    <= '0;
      val_rm_reg  <= '0;
      dest_reg    <= '0;
      pc_reg      <= '0;
      imm24_reg   <= '0;
    end else if (bus.flush || !bus.freeze) begin
      cond_reg    <= bus.cond_in;
      exe_cmd_reg <= bus.exe_cmd_in;
      val_rn_reg  <= bus.val_rn_in;
      val2_reg    <= bus.val2_in;
      val_rm_reg  <= bus.val_rm_in;
      dest_reg    <= bus.dest_in;
      pc_reg      <= bus.pc_in;
      imm24_reg   <= bus.imm24_in;
    end
  end

  assign live = valid_reg & cond_pass;

  // The EX instruction is never the one being flushed, so flush does not block this.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_reg <= 4'b0000;
    end else if (live && s_reg && !bus.freeze) begin
      status_reg <= bus.alu_status;
    end
  end

  assign imm_sext = {{(N-24){imm24_reg[23]}}, imm24_reg};

  assign bus.exe_cmd       = exe_cmd_reg;
  assign bus.val_rn        = val_rn_reg;
  assign bus.val2          = val2_reg;
  assign bus.val_rm        = val_rm_reg;
  assign bus.dest          = dest_reg;
  assign bus.pc            = pc_reg;
  assign bus.carry_in      = status_reg[ST_C];
  assign bus.wb_en         = live & wb_en_reg;
  assign bus.mem_r         = live & mem_r_reg;
  assign bus.mem_w         = live & mem_w_reg;
  assign bus.cond_pass     = cond_pass;
  assign bus.branch_taken  = live & b_reg;
  assign bus.branch_target = pc_reg + (imm_sext << 2);
  assign bus.status_q      = status_reg;

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Randomised and directed bench for ex_stage_ctrl with a queue-based scoreboard
// fed by a slot-level reference model.
module tb_ex_stage_ctrl;

  logic clk;
  logic rst;

  ex_stage_ctrl_if #(.N(32), .RA_W(4)) bus ();

  ex_stage_ctrl #(.N(32), .RA_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    bit          s;
    bit          wb;
    bit          mr;
    bit          mw;
    bit          b;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic [31:0] rn;
    logic [31:0] v2;
    logic [31:0] rm;
    logic [3:0]  dest;
    logic [31:0] pc;
    logic [23:0] imm;
    bit          known;
  } slot_t;

  typedef struct {
    slot_t      ex;
    logic [3:0] flags;
  } exp_t;

  slot_t      m_ex;
  logic [3:0] m_flags;
  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;

  function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  task automatic set_slot(input bit valid, input logic [3:0] cond, input logic [3:0] cmd,
                          input bit s, input bit wb, input bit mr, input bit mw, input bit b,
                          input logic [31:0] pc, input logic [23:0] imm);
    bus.valid_in   = valid;
    bus.cond_in    = cond;
    bus.exe_cmd_in = cmd;
    bus.s_in       = s;
    bus.wb_en_in   = wb;
    bus.mem_r_in   = mr;
    bus.mem_w_in   = mw;
    bus.b_in       = b;
    bus.val_rn_in  = $urandom;
    bus.val2_in    = $urandom;
    bus.val_rm_in  = $urandom;
    bus.dest_in    = 4'($urandom);
    bus.pc_in      = pc;
    bus.imm24_in   = imm;
  endtask

  task automatic rand_slot();
    logic [3:0] c;
    c = ($urandom_range(0, 9) < 4) ? 4'hE : 4'($urandom);
    set_slot(($urandom_range(0, 9) < 8), c, 4'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom, 24'($urandom));
  endtask

  // Applies the currently driven inputs to the model, queues the post-edge
  // expectation, and returns at the following falling edge.
  task automatic commit();
    slot_t      nx;
    logic [3:0] nf;
    nf = m_flags;
    if (m_ex.valid && cond_ok(m_ex.cond, m_flags) && m_ex.s && !bus.freeze)
      nf = bus.alu_status;
    if (bus.flush) begin
      nx = m_ex;
      nx.valid = 0; nx.s = 0; nx.wb = 0; nx.mr = 0; nx.mw = 0; nx.b = 0;
      nx.known = 0;
    end else if (bus.freeze) begin
      nx = m_ex;
    end else begin
      nx.valid = bus.valid_in;  nx.s  = bus.s_in;      nx.wb = bus.wb_en_in;
      nx.mr    = bus.mem_r_in;  nx.mw = bus.mem_w_in;  nx.b  = bus.b_in;
      nx.cond  = bus.cond_in;   nx.cmd = bus.exe_cmd_in;
      nx.rn    = bus.val_rn_in; nx.v2 = bus.val2_in;   nx.rm = bus.val_rm_in;
      nx.dest  = bus.dest_in;   nx.pc = bus.pc_in;     nx.imm = bus.imm24_in;
      nx.known = 1;
    end
    m_ex    = nx;
    m_flags = nf;
    sb_q.push_back('{ex: nx, flags: nf});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_zero_outputs();
    chk("rst_status_q", 32'(bus.status_q), 32'h0);
    chk("rst_carry_in", 32'(bus.carry_in), 32'h0);
    chk("rst_wb_en", 32'(bus.wb_en), 32'h0);
    chk("rst_mem_r", 32'(bus.mem_r), 32'h0);
    chk("rst_mem_w", 32'(bus.mem_w), 32'h0);
    chk("rst_branch_taken", 32'(bus.branch_taken), 32'h0);
    chk("rst_branch_target", bus.branch_target, 32'h0);
    chk("rst_cond_pass", 32'(bus.cond_pass), 32'h0);
    chk("rst_exe_cmd", 32'(bus.exe_cmd), 32'h0);
    chk("rst_val_rn", bus.val_rn, 32'h0);
    chk("rst_val2", bus.val2, 32'h0);
    chk("rst_val_rm", bus.val_rm, 32'h0);
    chk("rst_dest", 32'(bus.dest), 32'h0);
    chk("rst_pc", bus.pc, 32'h0);
  endtask

  task automatic model_reset();
    m_ex = '{default: 0};
    m_ex.known = 1;
    m_flags = 4'b0000;
  endtask

  // Monitor: one expectation per rising edge, compared just after it.
  initial begin
    exp_t        e;
    bit          pass, live;
    int          off;
    logic [31:0] tgt;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e    = sb_q.pop_front();
        pass = cond_ok(e.ex.cond, e.flags);
        live = e.ex.valid && pass;
        chk("status_q", 32'(bus.status_q), 32'(e.flags));
        chk("carry_in", 32'(bus.carry_in), 32'(e.flags[1]));
        chk("wb_en", 32'(bus.wb_en), 32'(live && e.ex.wb));
        chk("mem_r", 32'(bus.mem_r), 32'(live && e.ex.mr));
        chk("mem_w", 32'(bus.mem_w), 32'(live && e.ex.mw));
        chk("branch_taken", 32'(bus.branch_taken), 32'(live && e.ex.b));
        if (e.ex.known) begin
          off = int'($signed(e.ex.imm)) * 4;
          tgt = e.ex.pc + 32'(off);
          chk("cond_pass", 32'(bus.cond_pass), 32'(pass));
          chk("branch_target", bus.branch_target, tgt);
          chk("exe_cmd", 32'(bus.exe_cmd), 32'(e.ex.cmd));
          chk("val_rn", bus.val_rn, e.ex.rn);
          chk("val2", bus.val2, e.ex.v2);
          chk("val_rm", bus.val_rm, e.ex.rm);
          chk("dest", 32'(bus.dest), 32'(e.ex.dest));
          chk("pc", bus.pc, e.ex.pc);
        end
        $display("slot t=%0t v=%0d cond=%h flags=%h wb=%0d br=%0d", $time, e.ex.valid,
                 e.ex.cond, bus.status_q, bus.wb_en, bus.branch_taken);
      end
    end
  end

  initial begin
    int reset_at;
    rst = 1'b0;
    bus.freeze = 1'b0;
    bus.flush  = 1'b0;
    bus.alu_status = 4'b0000;
    set_slot(1, 4'hE, 4'h2, 1, 1, 1, 1, 1, 32'h40, 24'h10);

    // Asynchronous reset must clear outputs before any clock edge.
    #2 rst = 1'b1;
    #1 check_zero_outputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // SUBS sets Z, then BEQ taken with a negative offset.
    set_slot(1, 4'hE, 4'h4, 1, 1, 0, 0, 0, 32'h0, 24'h0);
    bus.alu_status = 4'b0100;
    commit();
    set_slot(1, 4'h0, 4'h0, 0, 0, 0, 0, 1, 32'h100, 24'hFFFFFE);
    commit();
    chk("beq_taken", 32'(bus.branch_taken), 32'h1);
    chk("beq_target", bus.branch_target, 32'h0F8);
    chk("subs_flags", 32'(bus.status_q), 32'h4);

    // Clear flags, then a condition-failed ADDS must have no side effects.
    set_slot(1, 4'hE, 4'h1, 1, 0, 0, 0, 0, 32'h0, 24'h0);
    bus.alu_status = 4'b0000;
    commit();
    set_slot(0, 4'hE, 4'h0, 0, 0, 0, 0, 0, 32'h0, 24'h0);
    commit();
    set_slot(1, 4'h0, 4'h2, 1, 1, 0, 0, 0, 32'h0, 24'h0);
    bus.alu_status = 4'b1001;
    commit();
    chk("failed_cond_wb_en", 32'(bus.wb_en), 32'h0);
    set_slot(0, 4'hE, 4'h0, 0, 0, 0, 0, 0, 32'h0, 24'h0);
    commit();
    chk("failed_cond_flags", 32'(bus.status_q), 32'h0);

    // Freeze holds an S instruction in EX and blocks its flag write.
    set_slot(1, 4'hE, 4'h6, 1, 1, 0, 0, 0, 32'h200, 24'h1);
    bus.alu_status = 4'b0110;
    commit();
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_slot();
      commit();
    end
    chk("freeze_flags_held", 32'(bus.status_q), 32'h0);
    chk("freeze_pc_held", bus.pc, 32'h200);
    bus.freeze = 1'b0;
    commit();
    chk("unfreeze_flags", 32'(bus.status_q), 32'h6);

    // Flush with freeze loads a bubble.
    set_slot(1, 4'hE, 4'h2, 0, 1, 0, 0, 0, 32'h300, 24'h0);
    commit();
    bus.flush = 1'b1; bus.freeze = 1'b1;
    set_slot(1, 4'hE, 4'h2, 0, 1, 0, 0, 0, 32'h400, 24'h0);
    commit();
    chk("flush_freeze_wb_en", 32'(bus.wb_en), 32'h0);
    // Flush without freeze still lets the EX instruction write flags.
    bus.flush = 1'b0; bus.freeze = 1'b0;
    set_slot(1, 4'hE, 4'h3, 1, 1, 0, 0, 0, 32'h500, 24'h0);
    bus.alu_status = 4'b1010;
    commit();
    bus.flush = 1'b1;
    commit();
    chk("flush_ex_update", 32'(bus.status_q), 32'hA);
    chk("flush_bubble_wb", 32'(bus.wb_en), 32'h0);
    bus.flush = 1'b0;

    // Full condition sweep: seed flags, then walk all 16 conditions.
    for (int f = 0; f < 16; f++) begin
      set_slot(1, 4'hE, 4'h1, 1, 0, 0, 0, 0, 32'h0, 24'h0);
      bus.alu_status = 4'(f);
      commit();
      for (int c = 0; c < 16; c++) begin
        set_slot(1, 4'(c), 4'h2, 0, 1, 0, 0, 0, $urandom, 24'($urandom));
        commit();
      end
    end

    // Random traffic with one asynchronous reset in the middle.
    reset_at = $urandom_range(100, 300);
    for (int k = 0; k < 400; k++) begin
      if (k == reset_at) begin
        #2 rst = 1'b1;
        #1 check_zero_outputs();
        model_reset();
        sb_q.push_back('{ex: m_ex, flags: m_flags});
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
      bus.freeze = ($urandom_range(0, 9) < 2);
      bus.flush  = ($urandom_range(0, 19) < 3);
      bus.alu_status = 4'($urandom);
      rand_slot();
      commit();
    end

    bus.freeze = 1'b0;
    bus.flush  = 1'b0;
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
